// File: rtl/corevx_tlb_if.sv
// Request/response bus between the cache/LSU (master) and corevx_tlb (slave).
interface corevx_tlb_if;
   localparam int unsigned VPN_W = 20;
   localparam int unsigned PPN_W = 22;

   logic             req_valid;
   logic             req_ready;
   logic [VPN_W-1:0] req_vaddr;
   logic [1:0]       req_cmd;
   logic             resp_valid;
   logic [PPN_W-1:0] resp_paddr;
   logic             resp_pagefault;
   logic             resp_accessfault;

   modport master (
      output req_valid, req_vaddr, req_cmd,
      input  req_ready, resp_valid, resp_paddr, resp_pagefault, resp_accessfault
   );

   modport slave (
      input  req_valid, req_vaddr, req_cmd,
      output req_ready, resp_valid, resp_paddr, resp_pagefault, resp_accessfault
   );
endinterface

// File: rtl/corevx_tlb.sv
// Fully-associative TLB in front of corevx_ptw with round-robin fill and sfence flush.
// Optional COREVX_TLB_STATS_EN adds stat_hits/stat_misses counters.
module corevx_tlb #(
   parameter int unsigned ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   corevx_tlb_if.slave bus,
   input  logic        satp_mode,
   input  logic        invalidate,
   output logic        ptw_resolve_request,
   input  logic        ptw_resolve_ack,
   output logic [19:0] ptw_virtual_address,
   input  logic        ptw_resolve_done,
   input  logic        ptw_resolve_pagefault,
   input  logic        ptw_resolve_accessfault,
   input  logic [7:0]  ptw_resolve_access_bits,
   input  logic [21:0] ptw_resolve_physical_address
`ifdef COREVX_TLB_STATS_EN
   ,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
`endif
);
   localparam int unsigned VPN_W = 20;
   localparam int unsigned PPN_W = 22;
   localparam int unsigned ACC_W = 8;
   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   localparam int unsigned A_V = 0;
   localparam int unsigned A_R = 1;
   localparam int unsigned A_W = 2;
   localparam int unsigned A_X = 3;
   localparam int unsigned A_U = 4;
   localparam int unsigned A_G = 5;
   localparam int unsigned A_A = 6;
   localparam int unsigned A_D = 7;

   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_EXEC  = 2'b11;

   typedef enum logic [1:0] {IDLE, PTW_REQ, PTW_WAIT} state_e;

   state_e             state_q, state_d;
   logic [ENTRIES-1:0] valid_q;
   logic [VPN_W-1:0]   tag_q [ENTRIES];
   logic [PPN_W-1:0]   ppn_q [ENTRIES];
   logic [ACC_W-1:0]   acc_q [ENTRIES];
   logic [IDX_W-1:0]   ptr_q;
   logic [VPN_W-1:0]   lat_vpn_q;
   logic [1:0]         lat_cmd_q;
   logic               kill_fill_q;

   logic               resp_valid_q, resp_valid_d;
   logic [PPN_W-1:0]   resp_paddr_q, resp_paddr_d;
   logic               resp_pf_q, resp_pf_d;
   logic               resp_af_q, resp_af_d;
   logic               ptw_req_q, ptw_req_d;

   logic               accept_c;
   logic               hit_c;
   logic [PPN_W-1:0]   hit_ppn_c;
   logic [ACC_W-1:0]   hit_acc_c;
   logic               lat_en_c;
   logic               fill_en_c;
   logic               unused_c;

   // Permission check on a translation's V/R/W/X/A/D bits for a given access type.
   function automatic logic perm_fault(input logic v, input logic r, input logic w,
                                       input logic x, input logic a, input logic d,
                                       input logic [1:0] cmd);
      logic is_w, is_x, is_r;
      is_w = (cmd == CMD_WRITE);
      is_x = (cmd == CMD_EXEC);
      is_r = !is_w && !is_x;
      return !v || !a || (is_r && !r) || (is_x && !x) || (is_w && (!w || !d));
   endfunction

   assign bus.req_ready       = (state_q == IDLE) && !invalidate;
   assign accept_c            = bus.req_valid && bus.req_ready;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_paddr      = resp_paddr_q;
   assign bus.resp_pagefault  = resp_pf_q;
   assign bus.resp_accessfault = resp_af_q;
   assign ptw_resolve_request = ptw_req_q;
   assign ptw_virtual_address = lat_vpn_q;
   assign unused_c            = ^{hit_acc_c[A_U], hit_acc_c[A_G]};

   // Tag lookup; at most one valid entry matches, so OR-merging the hit data is exact.
   always_comb begin
      hit_c     = 1'b0;
      hit_ppn_c = '0;
      hit_acc_c = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == bus.req_vaddr)) begin
            hit_c     = 1'b1;
            hit_ppn_c = hit_ppn_c | ppn_q[i];
            hit_acc_c = hit_acc_c | acc_q[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_paddr_d = resp_paddr_q;
      resp_pf_d    = 1'b0;
      resp_af_d    = 1'b0;
      lat_en_c     = 1'b0;
      fill_en_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (!satp_mode) begin
                  resp_valid_d = 1'b1;
                  resp_paddr_d = {2'b00, bus.req_vaddr};
               end else if (hit_c) begin
                  resp_valid_d = 1'b1;
                  resp_paddr_d = hit_ppn_c;
                  resp_pf_d    = perm_fault(hit_acc_c[A_V], hit_acc_c[A_R], hit_acc_c[A_W],
                                            hit_acc_c[A_X], hit_acc_c[A_A], hit_acc_c[A_D],
                                            bus.req_cmd);
               end else begin
                  lat_en_c = 1'b1;
                  state_d  = PTW_REQ;
               end
            end
         end
         PTW_REQ: begin
            if (ptw_resolve_ack) state_d = PTW_WAIT;
         end
         PTW_WAIT: begin
            if (ptw_resolve_done) begin
               resp_valid_d = 1'b1;
               state_d      = IDLE;
               if (ptw_resolve_accessfault) begin
                  resp_af_d    = 1'b1;
                  resp_paddr_d = '0;
               end else if (ptw_resolve_pagefault) begin
                  resp_pf_d    = 1'b1;
                  resp_paddr_d = '0;
               end else begin
                  resp_paddr_d = ptw_resolve_physical_address;
                  resp_pf_d    = perm_fault(ptw_resolve_access_bits[A_V],
                                            ptw_resolve_access_bits[A_R],
                                            ptw_resolve_access_bits[A_W],
                                            ptw_resolve_access_bits[A_X],
                                            ptw_resolve_access_bits[A_A],
                                            ptw_resolve_access_bits[A_D], lat_cmd_q);
                  fill_en_c    = !kill_fill_q && !invalidate;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ptw_req_d = (state_d == PTW_REQ);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         ptr_q        <= '0;
         lat_vpn_q    <= '0;
         lat_cmd_q    <= '0;
         kill_fill_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_paddr_q <= '0;
         resp_pf_q    <= 1'b0;
         resp_af_q    <= 1'b0;
         ptw_req_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_paddr_q <= resp_paddr_d;
         resp_pf_q    <= resp_pf_d;
         resp_af_q    <= resp_af_d;
         ptw_req_q    <= ptw_req_d;
         if (lat_en_c) begin
            lat_vpn_q <= bus.req_vaddr;
            lat_cmd_q <= bus.req_cmd;
         end
         // A flush at any point during a walk makes the walk's result stale.
         if (lat_en_c) kill_fill_q <= 1'b0;
         else if (invalidate && (state_q != IDLE)) kill_fill_q <= 1'b1;
         if (invalidate) begin
            valid_q <= '0;
         end else if (fill_en_c) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en_c) begin
         tag_q[ptr_q] <= lat_vpn_q;
         ppn_q[ptr_q] <= ptw_resolve_physical_address;
         acc_q[ptr_q] <= ptw_resolve_access_bits;
      end
   end

`ifdef COREVX_TLB_STATS_EN
   logic [31:0] hits_q, misses_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (accept_c && satp_mode && hit_c) hits_q <= hits_q + 32'd1;
         if (lat_en_c) misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`endif
endmodule
